// File: rtl/riscv_pkg.sv
// Shared core package.
// Holds the data-master IDs, the arbitration mode encoding and the
// data-bus address-phase request struct used by the MEM stage and data_bus_arb.
package riscv_pkg;

  // Data-bus master IDs
  localparam logic MST_LSU = 1'b0;
  localparam logic MST_AUX = 1'b1;

  // Arbitration mode
  typedef enum logic {
    ARB_FIXED = 1'b0,  // master 0 always wins a tie
    ARB_RR    = 1'b1   // master not granted most recently wins a tie
  } arb_mode_e;

  // Address-phase payload of one data-bus request
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } data_bus_req_t;

endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: synchronous 1-bit-wide FIFO holding the master ID of each
// accepted, unanswered data-bus transaction.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   push, push_id   enqueue push_id
//   pop             dequeue the head entry (ignored when empty)
//   head            ID of the oldest entry
//   full, empty     occupancy flags
//   count           occupancy (0..DEPTH)
// A push while full is accepted only if a pop happens in the same cycle.
module arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       push_id,
  input  logic       pop,
  output logic       head,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [2:0]       count_q, count_d;
  logic [2:0]       wr_idx;
  logic             do_push, do_pop;

  assign empty = (count_q == 3'd0);
  assign full  = (count_q == 3'(DEPTH));
  assign head  = mem_q[0];
  assign count = count_q;

  // Shift-register FIFO: entry 0 is always the head, so a pop shifts
  // everything down and a simultaneous push lands one slot lower.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = do_pop ? (mem_q >> 1) : mem_q;
    wr_idx  = do_pop ? (count_q - 3'd1) : count_q;
    if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (3'(i) == wr_idx) mem_d[i] = push_id;
      end
    end
    count_d = count_q + {2'b00, do_push} - {2'b00, do_pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q   <= '0;
      count_q <= 3'd0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/data_bus_arb.sv
// data_bus_arb: two-master arbiter for the core's single data-memory port.
// Master 0 is the LSU, master 1 an auxiliary master (debug/DMA).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   mX_req/wr/addr/wdata/byteen  master address phase (held until mX_gnt)
//   mX_gnt                       address phase accepted this cycle
//   mX_valid, mX_rdata           response routed back to the issuing master
//   data_req/wr/addr/wdata/byteen bus address phase, forwarded from the owner
//   data_gnt, data_valid, data_rdata  bus grant and response
//   outstanding                  accepted, unanswered transactions
//   proto_err                    sticky: data_valid with nothing outstanding
// Handshake: the address phase transfers in a cycle where data_req and
// data_gnt are both 1; the requester holds req and payload stable until
// then. Responses arrive in order, at the earliest one cycle after the grant.
module data_bus_arb
  import riscv_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit RR_EN           = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_valid,
  output logic        m1_valid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_byteen,
  input  logic        data_gnt,
  input  logic        data_valid,
  input  logic [31:0] data_rdata,
  output logic [2:0]  outstanding,
  output logic        proto_err
);

  localparam arb_mode_e MODE = RR_EN ? ARB_RR : ARB_FIXED;

  logic          lock_q, lock_d;
  logic          owner_q, owner_d;     // owner captured while locked
  logic          prio_q, prio_d;       // master that wins a tie
  logic          proto_err_q, proto_err_d;
  logic          owner, own_req;
  data_bus_req_t m0_bus, m1_bus, own_bus;
  logic          fifo_push, fifo_pop, fifo_head, fifo_full, fifo_empty;
  logic [2:0]    fifo_count;

  arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .push_id (owner),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    m0_bus = '{wr: m0_wr, addr: m0_addr, wdata: m0_wdata, byteen: m0_byteen};
    m1_bus = '{wr: m1_wr, addr: m1_addr, wdata: m1_wdata, byteen: m1_byteen};

    // Owner selection; a stalled address phase keeps its owner.
    if (lock_q)                 owner = owner_q;
    else if (m0_req && !m1_req) owner = MST_LSU;
    else if (m1_req && !m0_req) owner = MST_AUX;
    else if (m0_req && m1_req)  owner = (MODE == ARB_RR) ? prio_q : MST_LSU;
    else                        owner = prio_q;

    own_req = (owner == MST_AUX) ? m1_req : m0_req;
    // Payload is zeroed when the owner is idle so the bus never shows stale data.
    own_bus = own_req ? ((owner == MST_AUX) ? m1_bus : m0_bus) : '0;

    // Throttle on a full FIFO unless a response frees a slot this cycle.
    data_req    = own_req & ~(fifo_full & ~data_valid);
    data_wr     = own_bus.wr;
    data_addr   = own_bus.addr;
    data_wdata  = own_bus.wdata;
    data_byteen = own_bus.byteen;

    fifo_push = data_req & data_gnt;
    fifo_pop  = data_valid & ~fifo_empty;
    m0_gnt    = fifo_push & (owner == MST_LSU);
    m1_gnt    = fifo_push & (owner == MST_AUX);
    m0_valid  = fifo_pop & (fifo_head == MST_LSU);
    m1_valid  = fifo_pop & (fifo_head == MST_AUX);
    m0_rdata  = m0_valid ? data_rdata : 32'h0;
    m1_rdata  = m1_valid ? data_rdata : 32'h0;

    lock_d      = data_req & ~data_gnt;
    owner_d     = owner;
    prio_d      = prio_q;
    if (fifo_push && MODE == ARB_RR) prio_d = ~owner;
    proto_err_d = proto_err_q | (data_valid & fifo_empty);
  end

  assign outstanding = fifo_count;
  assign proto_err   = proto_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q      <= 1'b0;
      owner_q     <= MST_LSU;
      prio_q      <= MST_LSU;
      proto_err_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_data_bus_arb.sv
// Directed testbench for data_bus_arb. Instance dut uses the defaults
// (round-robin, 2 outstanding); instance dut_fix shares every input but
// uses fixed priority. Inputs change 1 ns after the rising edge, outputs
// are checked 1 ns later, well away from the next rising edge.
module tb_data_bus_arb;

  logic        clk, reset_n;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        data_gnt, data_valid;
  logic [31:0] data_rdata;

  logic        m0_gnt, m1_gnt, m0_valid, m1_valid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        data_req, data_wr;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_byteen;
  logic [2:0]  outstanding;
  logic        proto_err;

  logic        f_m0_gnt, f_m1_gnt, f_m0_valid, f_m1_valid;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic        f_data_req, f_data_wr;
  logic [31:0] f_data_addr, f_data_wdata;
  logic [3:0]  f_data_byteen;
  logic [2:0]  f_outstanding;
  logic        f_proto_err;

  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];   // expected response owner, oldest first

  data_bus_arb dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_valid(m0_valid), .m1_valid(m1_valid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_byteen(data_byteen), .data_gnt(data_gnt), .data_valid(data_valid), .data_rdata(data_rdata),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  data_bus_arb #(.MAX_OUTSTANDING(2), .RR_EN(1'b0)) dut_fix (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m0_gnt(f_m0_gnt), .m1_gnt(f_m1_gnt), .m0_valid(f_m0_valid), .m1_valid(f_m1_valid),
    .m0_rdata(f_m0_rdata), .m1_rdata(f_m1_rdata),
    .data_req(f_data_req), .data_wr(f_data_wr), .data_addr(f_data_addr), .data_wdata(f_data_wdata),
    .data_byteen(f_data_byteen), .data_gnt(data_gnt), .data_valid(data_valid), .data_rdata(data_rdata),
    .outstanding(f_outstanding), .proto_err(f_proto_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0; m0_byteen = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0; m1_byteen = 0;
    data_gnt = 0; data_valid = 0; data_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    tick();
  endtask

  // Response checker against the expected-owner queue (round-robin instance)
  task automatic check_resp(input string tag, input logic [31:0] rdata);
    logic [0:0] who;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    who = exp_q.pop_front();
    check_val({tag, "_m0_valid"}, 32'(m0_valid), 32'(who == 1'b0));
    check_val({tag, "_m1_valid"}, 32'(m1_valid), 32'(who == 1'b1));
    check_val({tag, "_rdata"}, (who == 1'b0) ? m0_rdata : m1_rdata, rdata);
    check_val({tag, "_other_rdata"}, (who == 1'b0) ? m1_rdata : m0_rdata, 32'h0);
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    #3;
    // Reset state
    check_val("rst_outstanding", 32'(outstanding), 32'd0);
    check_val("rst_proto_err", 32'(proto_err), 32'd0);
    check_val("rst_data_req", 32'(data_req), 32'd0);
    check_val("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    check_val("rst_valid", {30'd0, m1_valid, m0_valid}, 32'd0);
    check_val("rst_data_addr", data_addr, 32'd0);
    do_reset();

    // Single master load
    m0_req = 1; m0_addr = 32'h100; m0_byteen = 4'hf; data_gnt = 1;
    settle();
    check_val("single_data_req", 32'(data_req), 32'd1);
    check_val("single_data_addr", data_addr, 32'h100);
    check_val("single_byteen", 32'(data_byteen), 32'hf);
    check_val("single_m0_gnt", 32'(m0_gnt), 32'd1);
    check_val("single_m1_gnt", 32'(m1_gnt), 32'd0);
    check_val("single_out0", 32'(outstanding), 32'd0);
    tick();
    m0_req = 0; data_gnt = 0;
    settle();
    check_val("single_out1", 32'(outstanding), 32'd1);
    check_val("single_idle_req", 32'(data_req), 32'd0);
    tick();
    data_valid = 1; data_rdata = 32'hDEADBEEF;
    settle();
    check_val("single_m0_valid", 32'(m0_valid), 32'd1);
    check_val("single_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check_val("single_m1_valid", 32'(m1_valid), 32'd0);
    check_val("single_m1_rdata", m1_rdata, 32'h0);
    tick();
    data_valid = 0;
    settle();
    check_val("single_out_end", 32'(outstanding), 32'd0);
    check_val("single_no_err", 32'(proto_err), 32'd0);

    // Contention: RR instance alternates, fixed instance keeps m0
    do_reset();
    m0_req = 1; m0_addr = 32'h1000; m1_req = 1; m1_addr = 32'h2000; data_gnt = 1;
    for (int i = 0; i < 6; i++) begin
      data_valid = (i > 0); data_rdata = 32'hA000 + 32'(i);
      settle();
      check_val($sformatf("rr_m0_gnt_%0d", i), 32'(m0_gnt), 32'((i % 2) == 0));
      check_val($sformatf("rr_m1_gnt_%0d", i), 32'(m1_gnt), 32'((i % 2) == 1));
      check_val($sformatf("rr_addr_%0d", i), data_addr, ((i % 2) == 0) ? 32'h1000 : 32'h2000);
      if (i > 0) check_resp($sformatf("rr_resp_%0d", i), 32'hA000 + 32'(i));
      exp_q.push_back(1'((i % 2) == 1));
      check_val($sformatf("fix_m0_gnt_%0d", i), 32'(f_m0_gnt), 32'd1);
      check_val($sformatf("fix_m1_gnt_%0d", i), 32'(f_m1_gnt), 32'd0);
      if (i > 0) check_val($sformatf("fix_m0_valid_%0d", i), 32'(f_m0_valid), 32'd1);
      tick();
    end
    m0_req = 0; data_rdata = 32'hB000;
    settle();
    check_val("fix_m1_after_drop", 32'(f_m1_gnt), 32'd1);
    check_val("fix_addr_after_drop", f_data_addr, 32'h2000);
    check_resp("rr_resp_drop", 32'hB000);

    // Lock: m1 stalled 3 cycles, m0 joins in cycle 2
    do_reset();
    m1_req = 1; m1_addr = 32'h3000; m0_addr = 32'h1000; data_gnt = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) m0_req = 1;
      settle();
      check_val($sformatf("lock_addr_%0d", c), data_addr, 32'h3000);
      check_val($sformatf("lock_gnt_%0d", c), {30'd0, m1_gnt, m0_gnt}, 32'd0);
      tick();
    end
    data_gnt = 1;
    settle();
    check_val("lock_first_m1_gnt", 32'(m1_gnt), 32'd1);
    check_val("lock_first_m0_gnt", 32'(m0_gnt), 32'd0);
    check_val("lock_first_addr", data_addr, 32'h3000);
    exp_q.push_back(1'b1);
    tick();
    m1_req = 0;
    settle();
    check_val("lock_then_m0_gnt", 32'(m0_gnt), 32'd1);
    exp_q.push_back(1'b0);
    tick();
    m0_req = 0; data_gnt = 0; data_valid = 1;
    for (int k = 0; k < 2; k++) begin
      data_rdata = 32'hC000 + 32'(k);
      settle();
      check_resp($sformatf("lock_resp_%0d", k), 32'hC000 + 32'(k));
      tick();
    end
    data_valid = 0;

    // Throttle at MAX_OUTSTANDING=2
    do_reset();
    m0_req = 1; m0_addr = 32'h10; data_gnt = 1;
    tick();
    tick();
    settle();
    check_val("thr_out_full", 32'(outstanding), 32'd2);
    check_val("thr_req_blocked", 32'(data_req), 32'd0);
    check_val("thr_no_gnt", 32'(m0_gnt), 32'd0);
    tick();
    data_valid = 1; data_rdata = 32'h55;
    settle();
    check_val("thr_req_issue", 32'(data_req), 32'd1);
    check_val("thr_gnt_issue", 32'(m0_gnt), 32'd1);
    check_val("thr_valid", 32'(m0_valid), 32'd1);
    check_val("thr_rdata", m0_rdata, 32'h55);
    tick();
    m0_req = 0; data_valid = 0;
    settle();
    check_val("thr_out_same", 32'(outstanding), 32'd2);
    data_valid = 1;
    tick();
    tick();
    data_valid = 0;
    settle();
    check_val("thr_drained", 32'(outstanding), 32'd0);

    // Errors and reset
    data_valid = 1;
    settle();
    check_val("err_no_valid", {30'd0, m1_valid, m0_valid}, 32'd0);
    tick();
    data_valid = 0;
    settle();
    check_val("err_sticky", 32'(proto_err), 32'd1);
    m0_req = 1; data_gnt = 1;
    tick();
    m0_req = 0; data_gnt = 0;
    settle();
    check_val("err_out1", 32'(outstanding), 32'd1);
    check_val("err_still", 32'(proto_err), 32'd1);
    #2 reset_n = 0;
    #1;
    check_val("rst_async_out", 32'(outstanding), 32'd0);
    check_val("rst_async_err", 32'(proto_err), 32'd0);
    tick();
    reset_n = 1;
    tick();
    data_valid = 1;
    settle();
    check_val("rst_err_low", 32'(proto_err), 32'd0);
    tick();
    data_valid = 0;
    settle();
    check_val("rst_err_again", 32'(proto_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
